// File: rtl/fifo_pkg.sv
// Shared helpers for both halves of the async FIFO: Gray/binary conversion,
// depth derivation and the write-side flag bundle.
package fifo_pkg;

  // Functions work on 32 bits; callers size-cast to their pointer width.
  // Upper bits are zero, so the low bits of the result are exact.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  typedef struct packed {
    logic full;
    logic almost_full;
    logic overflow;
  } wr_flags_t;

endpackage

// File: rtl/async_fifo_wr_side_if.sv
// Write-domain bus of the async FIFO: write port, read-domain address/pointer
// inputs and the flag/level outputs.
interface async_fifo_wr_side_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  // Handshake: W_INC is a request accepted on the W_CLK edge only while W_FULL
  // is low; a request while full is dropped and flagged in W_OVERFLOW.
  logic [DATA_WIDTH-1:0] W_DATA;
  logic                  W_INC;
  logic                  W_CLR_OVF;
  logic [ADDR_WIDTH-1:0] R_ADDR;
  logic [ADDR_WIDTH:0]   RPTR_GRAY;
  logic [DATA_WIDTH-1:0] R_DATA;
  logic [ADDR_WIDTH:0]   WPTR_GRAY;
  logic                  W_FULL;
  logic                  W_ALMOST_FULL;
  logic [ADDR_WIDTH:0]   W_LEVEL;
  logic                  W_OVERFLOW;

  modport master (
    output W_DATA, W_INC, W_CLR_OVF, R_ADDR, RPTR_GRAY,
    input  R_DATA, WPTR_GRAY, W_FULL, W_ALMOST_FULL, W_LEVEL, W_OVERFLOW
  );

  modport slave (
    input  W_DATA, W_INC, W_CLR_OVF, R_ADDR, RPTR_GRAY,
    output R_DATA, WPTR_GRAY, W_FULL, W_ALMOST_FULL, W_LEVEL, W_OVERFLOW
  );
endinterface

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
module ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/async_fifo_wr_side.sv
// Write-domain half of the async FIFO: storage, write pointer, read-pointer
// synchronizer and the registered full/almost-full/level/overflow flags.
module async_fifo_wr_side
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int AF_LEVEL    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic W_CLK,
  input  logic W_RST,
  async_fifo_wr_side_if.slave bus
);
  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int PW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wbin, wbin_n, wgray, wgray_n;
  logic [PW-1:0] rq, rbin_s, full_cmp, level_q, level_n;
  wr_flags_t     flags_q;
  logic          wr_en, full_n, af_n;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (W_CLK),
    .rst_n (W_RST),
    .d     (bus.RPTR_GRAY),
    .q     (rq)
  );

  assign wr_en   = bus.W_INC & ~flags_q.full;
  assign wbin_n  = wbin + PW'(wr_en);
  assign wgray_n = PW'(bin2gray(32'(wbin_n)));
  assign rbin_s  = PW'(gray2bin(32'(rq)));

  // Full when the write pointer is exactly one lap ahead: in Gray code that is
  // the synchronized read pointer with its two MSBs inverted.
  assign full_cmp = rq ^ (PW'(3) << (PW - 2));
  assign full_n   = (wgray_n == full_cmp);
  assign level_n  = wbin_n - rbin_s;
  assign af_n     = (32'(level_n) >= 32'(AF_LEVEL));

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wbin[ADDR_WIDTH-1:0]] <= bus.W_DATA;
    end
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin    <= '0;
      wgray   <= '0;
      level_q <= '0;
      flags_q <= '0;
    end else begin
      wbin                <= wbin_n;
      wgray               <= wgray_n;
      level_q             <= level_n;
      flags_q.full        <= full_n;
      flags_q.almost_full <= af_n;
      // A new overflow wins over a clear in the same cycle.
      flags_q.overflow    <= (bus.W_INC & flags_q.full) |
                             (flags_q.overflow & ~bus.W_CLR_OVF);
    end
  end

  assign bus.R_DATA        = mem[bus.R_ADDR];
  assign bus.WPTR_GRAY     = wgray;
  assign bus.W_FULL        = flags_q.full;
  assign bus.W_ALMOST_FULL = flags_q.almost_full;
  assign bus.W_LEVEL       = level_q;
  assign bus.W_OVERFLOW    = flags_q.overflow;
endmodule

// File: tb/tb_async_fifo_wr_side.sv
// Bench for the async FIFO write side: directed boundary cases plus random
// traffic checked against a counter/queue model of FIFO occupancy.
module tb_async_fifo_wr_side;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int SS    = 2;

  // ---------------- clock / reset ----------------
  logic W_CLK = 1'b0;
  logic W_RST = 1'b0;
  always #5 W_CLK = ~W_CLK;

  async_fifo_wr_side_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  async_fifo_wr_side #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .AF_LEVEL    (AF),
    .SYNC_STAGES (SS)
  ) dut (
    .W_CLK (W_CLK),
    .W_RST (W_RST),
    .bus   (bus.slave)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            seen_q [$];
  int            w_cnt, r_cnt, m_level;
  bit            m_full, m_af, m_ovf;
  logic [DW-1:0] word19;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [PW-1:0] gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic reset_model();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    exp_q.delete();
    seen_q.delete();
    for (int i = 0; i < SS; i++) seen_q.push_back(0);
    w_cnt = 0; r_cnt = 0; m_level = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
  endtask

  // Read domain consumes n words; its pointer reaches the write side SS edges later.
  task automatic advance_read(input int n);
    r_cnt += n;
    for (int i = 0; i < n; i++) void'(exp_q.pop_front());
  endtask

  task automatic model_edge(input bit inc, input logic [DW-1:0] data, input bit clr);
    int seen;
    seen = seen_q.pop_front();
    m_ovf = (inc && m_full) || (m_ovf && !clr);
    if (inc && !m_full) begin
      m_mem[w_cnt % DEPTH] = data;
      exp_q.push_back(data);
      w_cnt++;
    end
    m_level = w_cnt - seen;
    m_full  = (m_level == DEPTH);
    m_af    = (m_level >= AF);
  endtask

  task automatic check_outputs(input logic [AW-1:0] raddr);
    chk("wptr_gray", bus.WPTR_GRAY, gray(w_cnt));
    chk("w_full", bus.W_FULL, m_full);
    chk("w_almost_full", bus.W_ALMOST_FULL, m_af);
    chk("w_level", bus.W_LEVEL, m_level);
    chk("w_overflow", bus.W_OVERFLOW, m_ovf);
    chk("r_data", bus.R_DATA, m_mem[raddr]);
    if (exp_q.size() > 0 && int'(raddr) == r_cnt % DEPTH)
      chk("head_word", bus.R_DATA, exp_q[0]);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit inc, input logic [DW-1:0] data, input bit clr,
                      input logic [AW-1:0] raddr);
    bus.W_INC     = inc;
    bus.W_DATA    = data;
    bus.W_CLR_OVF = clr;
    bus.R_ADDR    = raddr;
    bus.RPTR_GRAY = gray(r_cnt);
    seen_q.push_back(r_cnt);
    #1 chk("r_data_pre_edge", bus.R_DATA, m_mem[raddr]);
    @(posedge W_CLK);
    model_edge(inc, data, clr);
    @(negedge W_CLK);
    check_outputs(raddr);
  endtask

  // Asynchronous reset asserted mid-cycle with a write pending.
  task automatic do_reset();
    bus.W_INC     = 1'b1;
    bus.W_DATA    = DW'($urandom);
    bus.W_CLR_OVF = 1'b0;
    bus.RPTR_GRAY = '0;
    #2 W_RST = 1'b0;
    #1;
    chk("rst_wptr_gray", bus.WPTR_GRAY, 0);
    chk("rst_full", bus.W_FULL, 0);
    chk("rst_almost_full", bus.W_ALMOST_FULL, 0);
    chk("rst_level", bus.W_LEVEL, 0);
    chk("rst_overflow", bus.W_OVERFLOW, 0);
    for (int a = 0; a < DEPTH; a++) begin
      bus.R_ADDR = AW'(a);
      #1 chk("rst_r_data", bus.R_DATA, 0);
    end
    @(negedge W_CLK);
    chk("rst_hold_level", bus.W_LEVEL, 0);
    W_RST = 1'b1;
    bus.W_INC = 1'b0;
    reset_model();
  endtask

  // ---------------- sequence ----------------
  initial begin
    bus.W_INC = 0; bus.W_DATA = '0; bus.W_CLR_OVF = 0;
    bus.R_ADDR = '0; bus.RPTR_GRAY = '0;
    reset_model();
    @(negedge W_CLK);
    do_reset();

    // Fill to the boundary.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(8'hA0 + i), 1'b0, '0);
      if (i == 4) chk("fill_af_5", bus.W_ALMOST_FULL, 0);
      if (i == 5) chk("fill_af_6", bus.W_ALMOST_FULL, 1);
      if (i == 6) chk("fill_full_7", bus.W_FULL, 0);
      if (i == 7) chk("fill_full_8", bus.W_FULL, 1);
    end
    chk("fill_level", bus.W_LEVEL, 8);
    chk("fill_wptr_gray", bus.WPTR_GRAY, 4'b1100);
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, '0, 1'b0, AW'(a));
      chk("fill_mem", bus.R_DATA, DW'(8'hA0 + a));
    end

    // Overflow and clear-vs-set priority.
    step(1'b1, 8'hFF, 1'b0, '0);
    chk("ovf_mem0", bus.R_DATA, 8'hA0);
    chk("ovf_wptr_gray", bus.WPTR_GRAY, 4'b1100);
    chk("ovf_set", bus.W_OVERFLOW, 1);
    step(1'b1, 8'h11, 1'b1, '0);
    chk("ovf_clr_vs_set", bus.W_OVERFLOW, 1);
    step(1'b0, '0, 1'b1, '0);
    chk("ovf_cleared", bus.W_OVERFLOW, 0);

    // Drain seen only after the synchronizer delay.
    advance_read(3);
    step(1'b0, '0, 1'b0, '0);
    chk("drain_full_e1", bus.W_FULL, 1);
    step(1'b0, '0, 1'b0, '0);
    chk("drain_full_e2", bus.W_FULL, 1);
    step(1'b0, '0, 1'b0, '0);
    chk("drain_full_e3", bus.W_FULL, 0);
    chk("drain_level_e3", bus.W_LEVEL, 5);
    chk("drain_af_e3", bus.W_ALMOST_FULL, 0);

    // Same-address read during write.
    do_reset();
    step(1'b1, 8'h31, 1'b0, '0);
    step(1'b1, 8'h32, 1'b0, '0);
    step(1'b0, '0, 1'b0, 3'd2);
    chk("same_addr_old", bus.R_DATA, 8'h00);
    step(1'b1, 8'h5A, 1'b0, 3'd2);
    chk("same_addr_new", bus.R_DATA, 8'h5A);

    // Wrap-around with the read pointer tracking the writes.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      if (i == 19) word19 = d;
      advance_read(w_cnt - r_cnt);
      step(1'b1, d, 1'b0, 3'd3);
      chk("wrap_no_full", bus.W_FULL, 0);
    end
    chk("wrap_wptr_gray", bus.WPTR_GRAY, 4'b0110);
    chk("wrap_addr3", bus.R_DATA, word19);

    // Random traffic with a reset in the middle.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [AW-1:0] ra;
      if (c == 200) do_reset();
      if (r_cnt < w_cnt && $urandom_range(0, 2) == 0)
        advance_read($urandom_range(1, w_cnt - r_cnt));
      ra = ($urandom_range(0, 1) == 0) ? AW'(r_cnt % DEPTH) : AW'($urandom_range(0, DEPTH - 1));
      step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 15) == 0, ra);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
